// File: rtl/uart_word_pkg.sv
// Shared widths and FSM state type for the UART byte-to-word assembler.
package uart_word_pkg;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    IDLE,
    WAIT_LO
  } asm_state_t;
endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between the high and low byte of a word.
// expired flags the last idle cycle a partial word may survive.
module byte_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk920k,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  // Expiry is decided on the idle cycle that would move the count to TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 2);

  logic [TW-1:0] count;

  always_ff @(posedge clk920k or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else if (run)   count <= count + 1'b1;
  end

  assign expired = run && (count == LAST);
endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART bytes into 16-bit words (high byte first) behind a valid/ready
// output slot, with a running word count and inter-byte gap timeout.
module uart_word_assembler
  import uart_word_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk920k,
  input  logic              rst,
  input  logic [BYTE_W-1:0] uart_data,
  input  logic              data_valid,
  input  logic              word_ready,
  input  logic              cnt_clr,
  output logic [WORD_W-1:0] data_out,
  output logic              word_valid,
  output logic [WORD_W-1:0] data_out_tmp,
  output logic [WORD_W-1:0] data_counter,
  output logic              partial,
  output logic              overrun,
  output logic              timeout
);
  asm_state_t state, next_state;
  logic load_hi, load_lo, discard;
  logic timer_run, expired;
  logic slot_free, load_word, drop_word;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk920k (clk920k),
    .rst     (rst),
    .clear   (load_hi),
    .run     (timer_run),
    .expired (expired)
  );

  assign timer_run = (state == WAIT_LO) && !data_valid;

  always_ff @(posedge clk920k or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    next_state = state;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          load_hi    = 1'b1;
          next_state = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (data_valid) begin
          load_lo    = 1'b1;
          next_state = IDLE;
        end else if (expired) begin
          discard    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign slot_free = !word_valid || word_ready;
  assign load_word = load_lo && slot_free;
  assign drop_word = load_lo && !slot_free;
  assign partial   = (state == WAIT_LO);

  always_ff @(posedge clk920k or posedge rst) begin
    if (rst) begin
      data_out_tmp <= '0;
      data_out     <= '0;
      word_valid   <= 1'b0;
      data_counter <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (load_hi) data_out_tmp[15:8] <= uart_data;
      if (load_lo) data_out_tmp[7:0]  <= uart_data;
      if (discard) data_out_tmp       <= '0;
      timeout <= discard;

      if (load_word) begin
        data_out   <= {data_out_tmp[15:8], uart_data};
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end

      if (cnt_clr) begin
        data_counter <= '0;
        overrun      <= 1'b0;
      end else begin
        if (load_word) data_counter <= data_counter + 1'b1;
        if (drop_word) overrun      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed-vector bench for uart_word_assembler with TIMEOUT_CYCLES = 16.
module tb_uart_word_assembler;
  logic        clk920k = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  uart_data = '0;
  logic        data_valid = 1'b0;
  logic        word_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] data_out, data_out_tmp, data_counter;
  logic        word_valid, partial, overrun, timeout;

  int vectors = 0;
  int errors  = 0;

  uart_word_assembler #(.TIMEOUT_CYCLES(16)) dut (
    .clk920k      (clk920k),
    .rst          (rst),
    .uart_data    (uart_data),
    .data_valid   (data_valid),
    .word_ready   (word_ready),
    .cnt_clr      (cnt_clr),
    .data_out     (data_out),
    .word_valid   (word_valid),
    .data_out_tmp (data_out_tmp),
    .data_counter (data_counter),
    .partial      (partial),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 clk920k = ~clk920k;

  task automatic tick();
    @(posedge clk920k);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte strobe, returns #1 after the capturing edge.
  task automatic send(input logic [7:0] b);
    uart_data  = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset
    #1 rst = 1'b1;
    #1;
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_word_valid", {15'b0, word_valid}, 16'h0000);
    chk("rst_counter", data_counter, 16'h0000);
    chk("rst_flags", {13'b0, partial, overrun, timeout}, 16'h0000);
    tick();
    rst = 1'b0;

    // basic word 0x1234
    word_ready = 1'b1;
    send(8'h12);
    chk("t1_partial_hi", {15'b0, partial}, 16'h0001);
    chk("t1_tmp_hi", {data_out_tmp[15:8], 8'h00}, 16'h1200);
    send(8'h34);
    chk("t1_data_out", data_out, 16'h1234);
    chk("t1_word_valid", {15'b0, word_valid}, 16'h0001);
    chk("t1_counter", data_counter, 16'h0001);
    chk("t1_partial_lo", {15'b0, partial}, 16'h0000);
    chk("t1_tmp", data_out_tmp, 16'h1234);
    tick();
    chk("t1_consumed", {15'b0, word_valid}, 16'h0000);

    // overrun with a full slot
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    word_ready = 1'b0;
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    chk("t2_data_held", data_out, 16'hAABB);
    chk("t2_overrun", {15'b0, overrun}, 16'h0001);
    chk("t2_counter", data_counter, 16'h0001);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t2_clr_counter", data_counter, 16'h0000);
    chk("t2_clr_overrun", {15'b0, overrun}, 16'h0000);
    chk("t2_clr_keeps_word", data_out, 16'hAABB);
    chk("t2_clr_keeps_valid", {15'b0, word_valid}, 16'h0001);
    word_ready = 1'b1;
    tick();
    chk("t2_drained", {15'b0, word_valid}, 16'h0000);

    // gap timeout after 15 idle cycles
    send(8'h55);
    idle(14);
    chk("t3_still_partial", {15'b0, partial}, 16'h0001);
    chk("t3_no_timeout_yet", {15'b0, timeout}, 16'h0000);
    tick();
    chk("t3_timeout", {15'b0, timeout}, 16'h0001);
    chk("t3_idle", {15'b0, partial}, 16'h0000);
    chk("t3_tmp_cleared", data_out_tmp, 16'h0000);
    tick();
    chk("t3_timeout_pulse", {15'b0, timeout}, 16'h0000);
    send(8'h01);
    send(8'h02);
    chk("t3_realigned", data_out, 16'h0102);
    chk("t3_counter", data_counter, 16'h0001);

    // low byte on the expiry cycle
    send(8'h77);
    idle(14);
    send(8'h88);
    chk("t4_word", data_out, 16'h7788);
    chk("t4_no_timeout", {15'b0, timeout}, 16'h0000);
    tick();
    chk("t4_no_timeout_late", {15'b0, timeout}, 16'h0000);

    // low byte one cycle late becomes a new high byte
    send(8'h99);
    idle(15);
    chk("t4_late_timeout", {15'b0, timeout}, 16'h0001);
    send(8'hAB);
    chk("t4_new_hi_partial", {15'b0, partial}, 16'h0001);
    chk("t4_new_hi_tmp", {data_out_tmp[15:8], 8'h00}, 16'hAB00);
    send(8'hCD);
    chk("t4_new_word", data_out, 16'hABCD);
    chk("t4_counter", data_counter, 16'h0003);

    // counter wrap and clear coinciding with a load
    force dut.data_counter = 16'hFFFF;
    tick();
    release dut.data_counter;
    tick();
    chk("t5_preload", data_counter, 16'hFFFF);
    send(8'h11);
    send(8'h22);
    chk("t5_wrap", data_counter, 16'h0000);
    chk("t5_wrap_word", data_out, 16'h1122);
    send(8'h33);
    uart_data  = 8'h44;
    data_valid = 1'b1;
    cnt_clr    = 1'b1;
    tick();
    data_valid = 1'b0;
    cnt_clr    = 1'b0;
    chk("t5_clr_wins", data_counter, 16'h0000);
    chk("t5_clr_word", data_out, 16'h3344);
    chk("t5_clr_valid", {15'b0, word_valid}, 16'h0001);

    // asynchronous reset mid-word
    word_ready = 1'b0;
    tick();
    send(8'h55);
    send(8'h66);
    send(8'h77);
    chk("t6_pre_partial", {15'b0, partial}, 16'h0001);
    chk("t6_pre_valid", {15'b0, word_valid}, 16'h0001);
    rst = 1'b1;
    #2;
    chk("t6_rst_data_out", data_out, 16'h0000);
    chk("t6_rst_tmp", data_out_tmp, 16'h0000);
    chk("t6_rst_valid", {15'b0, word_valid}, 16'h0000);
    chk("t6_rst_counter", data_counter, 16'h0000);
    chk("t6_rst_flags", {13'b0, partial, overrun, timeout}, 16'h0000);
    rst = 1'b0;
    tick();
    chk("t6_no_timeout", {15'b0, timeout}, 16'h0000);
    word_ready = 1'b1;
    send(8'hDE);
    send(8'hAD);
    chk("t6_word", data_out, 16'hDEAD);
    chk("t6_counter", data_counter, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
